// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data memory between the pipeline MEM stage
// and a debug/loader port. The pipeline normally wins; a starvation counter
// forces a one-cycle pipeline stall so a waiting debug request always gets in.
// Debug reads return through a three-state FSM with a registered data return.
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int WORD_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  // MEM stage side
  input  logic                  in_cpu_rd_en,
  input  logic                  in_cpu_wr_en,
  input  logic [ADDR_WIDTH-1:0] in_cpu_rd_addr,
  input  logic [ADDR_WIDTH-1:0] in_cpu_wr_addr,
  input  logic [WORD_WIDTH-1:0] in_cpu_wr_word,
  output logic                  out_cpu_stall,
  // debug / loader side
  input  logic                  in_dbg_valid,
  input  logic                  in_dbg_write,
  input  logic [ADDR_WIDTH-1:0] in_dbg_addr,
  input  logic [WORD_WIDTH-1:0] in_dbg_wdata,
  output logic                  out_dbg_ready,
  output logic [WORD_WIDTH-1:0] out_dbg_rdata,
  output logic                  out_dbg_rdata_valid,
  // data memory side
  output logic [ADDR_WIDTH-1:0] out_mem_rd_addr,
  output logic [ADDR_WIDTH-1:0] out_mem_wr_addr,
  output logic [WORD_WIDTH-1:0] out_mem_wr_word,
  output logic                  out_mem_write_en,
  input  logic [WORD_WIDTH-1:0] in_mem_rd_word
);

  localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] LIMIT_C = CNT_WIDTH'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,     // no debug read outstanding
    RD_WAIT,  // debug read addressed last cycle, data arriving now
    RSP       // registered read data presented to the debug port
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_WIDTH-1:0]  r_starve_cnt;
  logic [WORD_WIDTH-1:0] r_dbg_rdata;

  logic w_cpu_act;
  logic w_starved;
  logic w_dbg_win;    // debug would win arbitration if it were requesting
  logic w_dbg_grant;  // debug actually owns memory this cycle

  assign w_cpu_act   = in_cpu_rd_en | in_cpu_wr_en;
  assign w_starved   = (r_starve_cnt == LIMIT_C);
  assign w_dbg_win   = (r_state == IDLE) && (!w_cpu_act || w_starved);
  assign w_dbg_grant = w_dbg_win && in_dbg_valid;

  assign out_dbg_ready       = w_dbg_win;
  assign out_cpu_stall       = w_dbg_grant && w_cpu_act;
  assign out_dbg_rdata       = r_dbg_rdata;
  assign out_dbg_rdata_valid = (r_state == RSP);

  // State register: debug read sequencing, cleared by reset (drops any read in flight).
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: a read walks IDLE -> RD_WAIT -> RSP -> IDLE; writes need no response.
  // NOTE: the default is assigned before the case so no path leaves
  // w_state_next unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_dbg_grant && !in_dbg_write) w_state_next = RD_WAIT;
      RD_WAIT: w_state_next = RSP;
      RSP:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Read-data return register: captures memory output while in RD_WAIT.
  // NOTE: this data register is reset so a read dropped by reset never leaves
  // stale data visible on the debug port.
  always_ff @(posedge clock) begin
    if (!reset)                 r_dbg_rdata <= '0;
    else if (r_state == RD_WAIT) r_dbg_rdata <= in_mem_rd_word;
  end

  // Starvation counter: counts cycles a debug request waits, saturating at the limit.
  always_ff @(posedge clock) begin
    if (!reset)                               r_starve_cnt <= '0;
    else if (w_dbg_grant)                     r_starve_cnt <= '0;
    else if (in_dbg_valid && !w_starved)      r_starve_cnt <= r_starve_cnt + CNT_WIDTH'(1);
  end

  // Memory mux: debug drives the port it uses; everything else follows the CPU.
  always_comb begin
    out_mem_rd_addr  = in_cpu_rd_addr;
    out_mem_wr_addr  = in_cpu_wr_addr;
    out_mem_wr_word  = in_cpu_wr_word;
    out_mem_write_en = in_cpu_wr_en && !out_cpu_stall;
    if (w_dbg_grant) begin
      out_mem_write_en = in_dbg_write;
      if (in_dbg_write) begin
        out_mem_wr_addr = in_dbg_addr;
        out_mem_wr_word = in_dbg_wdata;
      end else begin
        out_mem_rd_addr = in_dbg_addr;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a simple synchronous data memory
// model (one-cycle read latency, write at the clock edge).
module tb_dmem_arbiter;

  localparam int AW = 12;
  localparam int WW = 16;
  localparam int SL = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_rd_en, cpu_wr_en;
  logic [AW-1:0] cpu_rd_addr, cpu_wr_addr;
  logic [WW-1:0] cpu_wr_word;
  logic          cpu_stall;
  logic          dbg_valid, dbg_write;
  logic [AW-1:0] dbg_addr;
  logic [WW-1:0] dbg_wdata;
  logic          dbg_ready;
  logic [WW-1:0] dbg_rdata;
  logic          dbg_rdata_valid;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [WW-1:0] mem_wr_word;
  logic          mem_write_en;
  logic [WW-1:0] mem_rd_word;

  logic [WW-1:0] mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_errors = 0;

  dmem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .STARVE_LIMIT(SL)) dut (
    .clock               (clock),
    .reset               (reset),
    .in_cpu_rd_en        (cpu_rd_en),
    .in_cpu_wr_en        (cpu_wr_en),
    .in_cpu_rd_addr      (cpu_rd_addr),
    .in_cpu_wr_addr      (cpu_wr_addr),
    .in_cpu_wr_word      (cpu_wr_word),
    .out_cpu_stall       (cpu_stall),
    .in_dbg_valid        (dbg_valid),
    .in_dbg_write        (dbg_write),
    .in_dbg_addr         (dbg_addr),
    .in_dbg_wdata        (dbg_wdata),
    .out_dbg_ready       (dbg_ready),
    .out_dbg_rdata       (dbg_rdata),
    .out_dbg_rdata_valid (dbg_rdata_valid),
    .out_mem_rd_addr     (mem_rd_addr),
    .out_mem_wr_addr     (mem_wr_addr),
    .out_mem_wr_word     (mem_wr_word),
    .out_mem_write_en    (mem_write_en),
    .in_mem_rd_word      (mem_rd_word)
  );

  always #5 clock = ~clock;

  // Data memory model
  always @(posedge clock) begin
    mem_rd_word <= mem[mem_rd_addr];
    if (mem_write_en) mem[mem_wr_addr] <= mem_wr_word;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven, outputs checked at negedge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic cpu(input logic rd, input logic [AW-1:0] ra,
                     input logic wr, input logic [AW-1:0] wa, input logic [WW-1:0] wd);
    cpu_rd_en = rd; cpu_rd_addr = ra;
    cpu_wr_en = wr; cpu_wr_addr = wa; cpu_wr_word = wd;
  endtask

  task automatic dbg(input logic v, input logic w, input logic [AW-1:0] a, input logic [WW-1:0] d);
    dbg_valid = v; dbg_write = w; dbg_addr = a; dbg_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem_rd_word = '0;

    // ---- reset hold with every request asserted ----
    reset = 1'b0;
    cpu(1'b1, 12'h3F0, 1'b1, 12'h3FF, 16'h0000);
    dbg(1'b1, 1'b0, 12'h3F1, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      settle();
      check($sformatf("rst_valid_%0d", i), 32'(dbg_rdata_valid), 32'd0);
      check($sformatf("rst_cnt_%0d", i), 32'(dut.r_starve_cnt), 32'd0);
    end

    // ---- release: idle CPU, debug write 0x010 <= 0xBEEF accepted at once ----
    step();
    reset = 1'b1;
    cpu(1'b0, 12'h000, 1'b0, 12'h000, 16'h0000);
    dbg(1'b1, 1'b1, 12'h010, 16'hBEEF);
    settle();
    check("wr_ready", 32'(dbg_ready), 32'd1);
    check("wr_stall", 32'(cpu_stall), 32'd0);
    check("wr_we", 32'(mem_write_en), 32'd1);
    check("wr_addr", 32'(mem_wr_addr), 32'h010);
    check("wr_word", 32'(mem_wr_word), 32'hBEEF);
    step();
    check("wr_mem", 32'(mem[12'h010]), 32'hBEEF);

    // ---- debug read 0x010: accept T, return T+2 ----
    dbg(1'b1, 1'b0, 12'h010, 16'h0000);
    settle();
    check("rd_ready_T", 32'(dbg_ready), 32'd1);
    check("rd_addr_T", 32'(mem_rd_addr), 32'h010);
    check("rd_we_T", 32'(mem_write_en), 32'd0);
    step();
    dbg(1'b0, 1'b0, 12'h000, 16'h0000);
    settle();
    check("rd_ready_T1", 32'(dbg_ready), 32'd0);
    check("rd_valid_T1", 32'(dbg_rdata_valid), 32'd0);
    step();
    settle();
    check("rd_ready_T2", 32'(dbg_ready), 32'd0);
    check("rd_valid_T2", 32'(dbg_rdata_valid), 32'd1);
    check("rd_data_T2", 32'(dbg_rdata), 32'hBEEF);
    step();
    settle();
    check("rd_valid_T3", 32'(dbg_rdata_valid), 32'd0);

    // ---- back-to-back debug writes with the CPU idle ----
    step();
    for (int i = 0; i < 3; i++) begin
      dbg(1'b1, 1'b1, 12'(12'h011 + i), 16'(16'hA5A0 + i));
      settle();
      check($sformatf("b2b_ready_%0d", i), 32'(dbg_ready), 32'd1);
      step();
    end
    dbg(1'b0, 1'b0, 12'h000, 16'h0000);
    check("b2b_mem0", 32'(mem[12'h011]), 32'hA5A0);
    check("b2b_mem2", 32'(mem[12'h013]), 32'hA5A2);

    // ---- continuous CPU loads starve a debug read of 0x012 ----
    cpu(1'b1, 12'h005, 1'b0, 12'h000, 16'h0000);
    dbg(1'b1, 1'b0, 12'h012, 16'h0000);
    for (int i = 0; i < SL; i++) begin
      settle();
      check($sformatf("starve_ready_%0d", i), 32'(dbg_ready), 32'd0);
      check($sformatf("starve_stall_%0d", i), 32'(cpu_stall), 32'd0);
      check($sformatf("starve_addr_%0d", i), 32'(mem_rd_addr), 32'h005);
      step();
    end
    settle();
    check("forced_ready", 32'(dbg_ready), 32'd1);
    check("forced_stall", 32'(cpu_stall), 32'd1);
    check("forced_addr", 32'(mem_rd_addr), 32'h012);
    step();
    dbg(1'b0, 1'b0, 12'h000, 16'h0000);
    settle();
    check("forced_stall_T1", 32'(cpu_stall), 32'd0);
    check("forced_cpu_addr_T1", 32'(mem_rd_addr), 32'h005);
    step();
    settle();
    check("forced_valid_T2", 32'(dbg_rdata_valid), 32'd1);
    check("forced_data_T2", 32'(dbg_rdata), 32'hA5A1);
    step();

    // ---- CPU store collides with a starved debug write to 0x020 ----
    dbg(1'b1, 1'b1, 12'h020, 16'h5555);
    for (int i = 0; i < SL; i++) begin
      settle();
      check($sformatf("coll_wait_%0d", i), 32'(dbg_ready), 32'd0);
      step();
    end
    cpu(1'b0, 12'h005, 1'b1, 12'h020, 16'h1234);
    settle();
    check("coll_stall", 32'(cpu_stall), 32'd1);
    check("coll_we", 32'(mem_write_en), 32'd1);
    check("coll_word", 32'(mem_wr_word), 32'h5555);
    step();
    check("coll_mem_dbg", 32'(mem[12'h020]), 32'h5555);
    dbg(1'b0, 1'b0, 12'h000, 16'h0000);
    settle();
    check("retry_stall", 32'(cpu_stall), 32'd0);
    check("retry_we", 32'(mem_write_en), 32'd1);
    check("retry_word", 32'(mem_wr_word), 32'h1234);
    step();
    check("retry_mem", 32'(mem[12'h020]), 32'h1234);

    // ---- debug valid held across RD_WAIT/RSP of a prior read ----
    cpu(1'b0, 12'h000, 1'b0, 12'h000, 16'h0000);
    dbg(1'b1, 1'b0, 12'h020, 16'h0000);
    settle();
    check("hold_ready_T", 32'(dbg_ready), 32'd1);
    step();
    cpu(1'b1, 12'h005, 1'b0, 12'h000, 16'h0000);
    dbg(1'b1, 1'b0, 12'h010, 16'h0000);
    settle();
    check("hold_ready_T1", 32'(dbg_ready), 32'd0);
    step();
    check("hold_cnt_T1", 32'(dut.r_starve_cnt), 32'd1);
    settle();
    check("hold_valid_T2", 32'(dbg_rdata_valid), 32'd1);
    check("hold_data_T2", 32'(dbg_rdata), 32'h1234);
    step();
    check("hold_cnt_T2", 32'(dut.r_starve_cnt), 32'd2);
    cpu(1'b0, 12'h000, 1'b0, 12'h000, 16'h0000);
    settle();
    check("hold_ready_T3", 32'(dbg_ready), 32'd1);
    check("hold_addr_T3", 32'(mem_rd_addr), 32'h010);
    step();

    // ---- reset asserted while in RD_WAIT drops the read ----
    reset = 1'b0;
    dbg(1'b0, 1'b0, 12'h000, 16'h0000);
    step();
    reset = 1'b1;
    dbg(1'b1, 1'b1, 12'h3F0, 16'h0001);
    settle();
    check("rstrd_valid", 32'(dbg_rdata_valid), 32'd0);
    check("rstrd_data", 32'(dbg_rdata), 32'd0);
    check("rstrd_ready", 32'(dbg_ready), 32'd1);
    step();
    dbg(1'b0, 1'b0, 12'h000, 16'h0000);
    settle();
    check("rstrd_valid_next", 32'(dbg_rdata_valid), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data memory between the pipeline MEM stage and a debug/loader access port. The pipeline has priority. A starvation counter guarantees the debug port a slot by stalling the pipeline for one cycle. The block sits between the MEM stage outputs and `dmem_sim`. Debug reads complete over a small FSM with registered read-data return.

## Interface
- `ADDR_WIDTH`, 12: dmem address width
- `WORD_WIDTH`, 16: dmem word width
- `STARVE_LIMIT`, 4: consecutive denied debug-request cycles before the pipeline is forcibly stalled (≥1)
- `clock`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low; sampled on rising edge of `clock`
- `in_cpu_rd_en` / `in_cpu_wr_en`  in  1 each  MEM stage load / store this cycle
- `in_cpu_rd_addr`, `in_cpu_wr_addr`  in  ADDR_WIDTH each  MEM stage addresses
- `in_cpu_wr_word`  in  WORD_WIDTH  store data
- `out_cpu_stall`  out  1  pipeline must hold MEM and earlier stages this cycle
- `in_dbg_valid`  in  1  debug request pending
- `in_dbg_write`  in  1  1 = write, 0 = read
- `in_dbg_addr`  in  ADDR_WIDTH; `in_dbg_wdata`  in  WORD_WIDTH
- `out_dbg_ready`  out  1  request accepted when `in_dbg_valid & out_dbg_ready`
- `out_dbg_rdata`  out  WORD_WIDTH; `out_dbg_rdata_valid`  out  1  one-cycle read-return pulse
- `out_mem_rd_addr`, `out_mem_wr_addr`  out  ADDR_WIDTH; `out_mem_wr_word`  out  WORD_WIDTH; `out_mem_write_en`  out  1  to dmem
- `in_mem_rd_word`  in  WORD_WIDTH  dmem read data; valid the cycle after its address is presented

## Operation
- A CPU access is active when `cpu_act = in_cpu_rd_en | in_cpu_wr_en`.
- FSM states:
  - `IDLE`: no debug read outstanding.
  - `RD_WAIT`: debug read addressed last cycle; data is on `in_mem_rd_word` this cycle.
  - `RSP`: `out_dbg_rdata_valid = 1`.
- FSM transitions:
  - `IDLE`→`RD_WAIT` on an accepted debug read.
  - `RD_WAIT`→`RSP` unconditionally. In `RD_WAIT`, capture `in_mem_rd_word` into the `out_dbg_rdata` register.
  - `RSP`→`IDLE` unconditionally.
- Grant rules, evaluated in `IDLE`:
  - `starved = (starve_cnt == STARVE_LIMIT)`.
  - Debug is granted if `in_dbg_valid & (!cpu_act | starved)`.
  - If debug is granted while `cpu_act`, assert `out_cpu_stall = 1`. The CPU request is not issued to memory.
  - `out_dbg_ready = 1` in `IDLE` exactly when debug would be granted. It is 0 in `RD_WAIT` and `RSP`.
- In `RD_WAIT` and `RSP` the CPU owns the memory; `out_cpu_stall = 0`.
- Memory mux:
  - When debug is granted: a write drives `out_mem_wr_addr = in_dbg_addr`, `out_mem_wr_word = in_dbg_wdata`, `out_mem_write_en = 1`. A read drives `out_mem_rd_addr = in_dbg_addr`, `out_mem_write_en = 0`.
  - Otherwise the CPU signals pass through, with `out_mem_write_en = in_cpu_wr_en & !out_cpu_stall`.
  - Unused address outputs carry the CPU values.
- Starvation counter `starve_cnt`, width `clog2(STARVE_LIMIT+1)`:
  - Cleared on a debug grant.
  - Incremented (saturating at `STARVE_LIMIT`) in any cycle with `in_dbg_valid` and no grant. This includes cycles in `RD_WAIT` and `RSP`.
  - Held when `!in_dbg_valid`.
- Debug writes complete at acceptance; they have no response.

## Timing
- Reset (`reset = 0` at edge) sets: state `IDLE`, `starve_cnt = 0`, `out_dbg_rdata = 0`, `out_dbg_rdata_valid = 0`. All combinational outputs follow, so `out_cpu_stall = 0` unless the debug-grant conditions hold.
- Reset mid-read: any outstanding read is dropped and no `out_dbg_rdata_valid` pulse is issued.
- `out_cpu_stall`, `out_dbg_ready` and the memory mux are combinational from the inputs, state and `starve_cnt`. They are valid in the same cycle.
- Debug read latency: accepted in cycle T, `out_dbg_rdata_valid = 1` in T+2, `out_dbg_rdata = mem[addr]`. The next debug request can be accepted in T+3.
- Debug write: accepted in T, memory updated at the end of T.
- Worst-case debug wait under continuous CPU traffic is `STARVE_LIMIT` denied cycles, with acceptance on the next cycle.
- The stall lasts exactly one cycle per forced grant.
- Back-to-back debug writes with the CPU idle are accepted every cycle.

## Test plan
- Reset hold: `reset = 0` for 3 cycles with all requests high → `out_dbg_rdata_valid = 0`, `starve_cnt = 0`. First cycle after release with CPU idle: `out_dbg_ready = 1`.
- Idle CPU, debug write addr 0x010 data 0xBEEF, then debug read 0x010 → write accepted same cycle. Read accepted at T, `out_dbg_rdata_valid` at T+2 with 0xBEEF. `out_dbg_ready = 0` in T+1 and T+2.
- Continuous CPU loads, `STARVE_LIMIT = 4`, debug read held valid → 4 cycles with `out_dbg_ready = 0`. Fifth cycle: `out_dbg_ready = 1` and `out_cpu_stall = 1` for exactly one cycle. Data returns 2 cycles later.
- CPU store 0x1234 to 0x020 on the same cycle a starved debug write of 0x5555 to 0x020 is granted → memory holds 0x5555, `out_mem_write_en` is from debug, CPU stalled. Store retried next cycle → memory holds 0x1234.
- Debug valid held across `RD_WAIT`/`RSP` of a prior read → `starve_cnt` increments in those cycles. Grant follows on return to `IDLE` when the CPU is idle or the counter is saturated.
- Reset asserted in `RD_WAIT` → no valid pulse. State `IDLE` next cycle, `out_dbg_rdata = 0`.
